// File: rtl/rv32i_dmem_responder_if.sv
// rv32i_dmem_responder_if: core data-port bus between the RV32I core (master) and the data responder (slave)
interface rv32i_dmem_responder_if;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0] byteenable;
  logic write;
  logic read;
  logic waitrequest;
  modport master(output address, write, writedata, byteenable, read, input readdata, waitrequest);
  modport slave(input address, write, writedata, byteenable, read, output readdata, waitrequest);
endinterface

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: data RAM with byte-lane writes and wait-stated reads for the RV32I core
// Define RV32I_DMEM_TIMER_EN to add the memory-mapped mtime/mtimecmp timer driving irq.
module rv32i_dmem_responder #(
  parameter int LOG2_DMEM_WORDS = 12,
  parameter int WAIT_STATES = 1,
  parameter logic [31:0] TIMER_BASE = 32'hAFFFFFE0
) (
  input logic clk,
  input logic reset_n,
  rv32i_dmem_responder_if.slave bus,
  output logic irq
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic [LOG2_DMEM_WORDS-1:0] widx, cap_idx;
  logic [31:0] mem [1<<LOG2_DMEM_WORDS];
  logic start, timer_hit, ram_we;
  logic [31:0] ram_word, rd_word;
  assign widx = bus.address[LOG2_DMEM_WORDS+1:2];
  assign start = (state == IDLE) & bus.read;
  assign ram_we = bus.write & ~timer_hit;
  assign ram_word = mem[cap_idx];
  always_comb begin
    state_nxt = state;
    wcnt_nxt = wcnt;
    case (state)
      IDLE: if (bus.read) begin
        wcnt_nxt = 4'(WAIT_STATES);
        state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        wcnt_nxt = bus.read ? wcnt - 4'd1 : '0;
        state_nxt = !bus.read ? IDLE : (wcnt == 4'd1) ? RESP : WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wcnt <= '0;
      cap_idx <= '0;
    end else begin
      state <= state_nxt;
      wcnt <= wcnt_nxt;
      if (start) cap_idx <= widx;
    end
  end
  // RAM read is asynchronous so a write in the capture cycle is visible in RESP
  always_ff @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (bus.byteenable[i]) mem[widx][8*i +: 8] <= bus.writedata[8*i +: 8];
  end
  assign bus.waitrequest = reset_n & bus.read & (state != RESP);
  assign bus.readdata = (state == RESP) ? rd_word : '0;
`ifdef RV32I_DMEM_TIMER_EN
  logic [63:0] mtime, mtimecmp, mtime_nxt, cmp_nxt;
  logic [31:0] timer_word;
  logic [1:0] cap_reg;
  logic cap_timer, tw;
  logic unused_bits;
  assign unused_bits = ^bus.address[1:0];
  assign timer_hit = bus.address[31:4] == TIMER_BASE[31:4];
  assign tw = bus.write & timer_hit & (bus.byteenable == 4'hF);
  assign mtime_nxt = (tw & (bus.address[3:2] == 2'd0)) ? {mtime[63:32], bus.writedata} :
                     (tw & (bus.address[3:2] == 2'd1)) ? {bus.writedata, mtime[31:0]} : mtime + 64'd1;
  assign cmp_nxt = (tw & (bus.address[3:2] == 2'd2)) ? {mtimecmp[63:32], bus.writedata} :
                   (tw & (bus.address[3:2] == 2'd3)) ? {bus.writedata, mtimecmp[31:0]} : mtimecmp;
  assign timer_word = cap_reg[1] ? (cap_reg[0] ? mtimecmp[63:32] : mtimecmp[31:0])
                                 : (cap_reg[0] ? mtime[63:32] : mtime[31:0]);
  assign rd_word = cap_timer ? timer_word : ram_word;
  // compare against the incoming mtimecmp so raising it drops irq on the next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime <= '0;
      mtimecmp <= '1;
      irq <= 1'b0;
      cap_reg <= '0;
      cap_timer <= 1'b0;
    end else begin
      mtime <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      irq <= mtime >= cmp_nxt;
      if (start) begin
        cap_reg <= bus.address[3:2];
        cap_timer <= timer_hit;
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{bus.address[31:LOG2_DMEM_WORDS+2], bus.address[1:0]};
  assign timer_hit = 1'b0;
  assign rd_word = ram_word;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// tb_rv32i_dmem_responder: directed bench with a transaction-level model of the data responder
module tb_rv32i_dmem_responder;
  localparam int LW = 4;
  localparam int WS = 3;
  localparam logic [31:0] TB = 32'hAFFFFFE0;
`ifdef RV32I_DMEM_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;
  rv32i_dmem_responder_if bus();
  rv32i_dmem_responder #(.LOG2_DMEM_WORDS(LW), .WAIT_STATES(WS), .TIMER_BASE(TB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq));
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] m_mem [16];
  logic [3:0] m_val [16] = '{default: 4'h0};
  logic [63:0] m_time = '0, m_cmp = '1, t_old;
  logic m_irq = 1'b0, cmpl;
  int age = 0;
  logic [31:0] cap = '0;

  function automatic logic thit(input logic [31:0] a);
    return TIMER && (a[31:4] == TB[31:4]);
  endfunction
  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (!thit(a)) return m_mem[a[5:2]];
    case (a[3:2])
      2'd0: return m_time[31:0];
      2'd1: return m_time[63:32];
      2'd2: return m_cmp[31:0];
      default: return m_cmp[63:32];
    endcase
  endfunction
  function automatic logic m_known(input logic [31:0] a);
    return thit(a) || (m_val[a[5:2]] == 4'hF);
  endfunction

  // age = cycles the current read has been held; it completes at age WS+1
  always @(posedge clk) begin
    if (!reset_n) begin
      age = 0;
      m_time = '0;
      m_cmp = '1;
      m_irq = 1'b0;
    end else begin
      t_old = m_time;
      m_time = m_time + 64'd1;
      if (bus.write) begin
        if (thit(bus.address)) begin
          if (bus.byteenable == 4'hF)
            case (bus.address[3:2])
              2'd0: m_time = {t_old[63:32], bus.writedata};
              2'd1: m_time = {bus.writedata, t_old[31:0]};
              2'd2: m_cmp[31:0] = bus.writedata;
              default: m_cmp[63:32] = bus.writedata;
            endcase
        end else
          for (int i = 0; i < 4; i++)
            if (bus.byteenable[i]) begin
              m_mem[bus.address[5:2]][8*i +: 8] = bus.writedata[8*i +: 8];
              m_val[bus.address[5:2]][i] = 1'b1;
            end
      end
      m_irq = t_old >= m_cmp;
      cmpl = bus.read && (age == WS + 1);
      if (bus.read && age == 0) cap = bus.address;
      age = (bus.read && !cmpl) ? age + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_waitrequest", 32'(bus.waitrequest), 32'd0);
      check("rst_readdata", bus.readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
    end else begin
      check("waitrequest", 32'(bus.waitrequest), 32'(bus.read && age <= WS));
      check("irq", 32'(irq), 32'(m_irq));
      if (bus.read && age == WS + 1 && m_known(cap)) check("readdata", bus.readdata, m_rd(cap));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address = a;
    bus.writedata = d;
    bus.byteenable = be;
    bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic wen, input logic [31:0] wdat,
                    output logic [31:0] d, output int st);
    bus.address = a;
    bus.read = 1'b1;
    bus.write = wen;
    bus.writedata = wdat;
    bus.byteenable = 4'hF;
    st = 0;
    d = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.waitrequest) begin
        d = bus.readdata;
        break;
      end
      st++;
      @(posedge clk); #1;
      bus.write = 1'b0;
    end
    @(posedge clk); #1;
    bus.write = 1'b0;
    bus.read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int st, cnt, c;
    bus.read = 1'b1;
    bus.write = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    bus.byteenable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold_waitrequest", 32'(bus.waitrequest), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd(32'h0, 1'b0, 32'h0, d, st);
    check("first_read_stalls", 32'(st), 32'(WS + 1));
    wr(32'h100, 32'h11223344, 4'hF);
    wr(32'h100, 32'hAABBCCDD, 4'b0101);
    rd(32'h100, 1'b0, 32'h0, d, st);
    check("byte_lane_data", d, 32'h11BB33DD);
    check("byte_lane_stalls", 32'(st), 32'd4);
    rd(32'h8, 1'b1, 32'h55667788, d, st);
    check("read_with_write", d, 32'h55667788);
    wr(32'hC, 32'h0BADF00D, 4'hF);
    rd(32'hC, 1'b0, 32'h0, d, st);
    check("write_then_read", d, 32'h0BADF00D);
    bus.address = 32'h100;
    bus.read = 1'b1;
    @(negedge clk);
    check("abandon_stall", 32'(bus.waitrequest), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.read = 1'b0;
    @(posedge clk); #1;
    rd(32'hC, 1'b0, 32'h0, d, st);
    check("after_abandon_data", d, 32'h0BADF00D);
    check("after_abandon_stalls", 32'(st), 32'd4);
    wr(32'h4, 32'hDEADBEEF, 4'hF);
    rd(32'h44, 1'b0, 32'h0, d, st);
    check("alias_data", d, 32'hDEADBEEF);
    bus.address = 32'h44;
    bus.read = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.waitrequest) cnt++;
      @(posedge clk); #1;
    end
    check("back_to_back_completions", 32'(cnt), 32'd2);
    bus.address = 32'h4;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_reset_waitrequest", 32'(bus.waitrequest), 32'd0);
    check("mid_reset_readdata", bus.readdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd(32'h4, 1'b0, 32'h0, d, st);
    check("post_reset_data", d, 32'hDEADBEEF);
    check("post_reset_stalls", 32'(st), 32'd4);
`ifdef RV32I_DMEM_TIMER_EN
    wr(TB, 32'h0, 4'hF);
    wr(TB + 32'hC, 32'h0, 4'hF);
    wr(TB + 32'h8, 32'h40, 4'hF);
    for (c = 3; c < 300; c++) begin
      @(negedge clk);
      if (irq) break;
    end
    check("irq_rise_cycle", 32'(c), 32'd66);
    @(posedge clk); #1;
    wr(TB + 32'h8, 32'h1000, 4'hF);
    @(negedge clk);
    check("irq_fall", 32'(irq), 32'd0);
    @(posedge clk); #1;
    wr(TB + 32'h8, 32'h0, 4'h3);
    rd(TB + 32'h8, 1'b0, 32'h0, d, st);
    check("mtimecmp_partial_ignored", d, 32'h1000);
    rd(TB + 32'h4, 1'b0, 32'h0, d, st);
    check("mtime_hi", d, 32'h0);
`else
    wr(TB, 32'h12345678, 4'hF);
    rd(32'h20, 1'b0, 32'h0, d, st);
    check("timer_base_aliases_ram", d, 32'h12345678);
    check("irq_tied_low", 32'(irq), 32'd0);
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
